// File: rtl/morse_key_decoder.sv
// Morse key front end: synchronizes and debounces a raw key, times marks and gaps
// in dot units, and emits letter codes with a fixed-width load strobe.
module morse_key_decoder #(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int UNIT_CYC     = 5000000,
   parameter int STB_CYC      = 64
) (
   input  logic       CLOCK,
   input  logic       RST_N,
   input  logic       key_in,
   output logic [7:0] letter,
   output logic       letter_stb,
   output logic       key_led,
   output logic       err
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int UW = $clog2(UNIT_CYC + 1);
   localparam int SW = $clog2(STB_CYC + 1);
   localparam logic [7:0] CODE_SPACE = 8'd27;
   localparam logic [7:0] CODE_ERR   = 8'd29;

   typedef enum logic [1:0] {IDLE, MARK, GAP, EMIT} state_t;

   logic          sync1, sync2;
   logic [DW-1:0] deb_cnt;
   logic          deb, deb_q;
   logic          rise, fall;
   logic [UW-1:0] unit_cnt;
   logic [3:0]    units;
   state_t        state;
   logic [2:0]    len;
   logic [3:0]    bits;
   logic          ovf, word_pending, emit_space, stb_go;
   logic [SW-1:0] stb_cnt;
   logic [7:0]    code;

   assign key_led = deb;
   assign rise    = deb & ~deb_q;
   assign fall    = ~deb & deb_q;

   // Element i of the pattern lives in bits[i]; dot=0, dash=1, unused bits are zero.
   function automatic logic [7:0] lookup(input logic [2:0] n, input logic [3:0] b, input logic o);
      logic [7:0] c;
      c = CODE_ERR;
      if (!o) begin
         case ({n, b})
            {3'd2, 4'b0010}: c = 8'd1;   // A .-
            {3'd4, 4'b0001}: c = 8'd2;   // B -...
            {3'd4, 4'b0101}: c = 8'd3;   // C -.-.
            {3'd3, 4'b0001}: c = 8'd4;   // D -..
            {3'd1, 4'b0000}: c = 8'd5;   // E .
            {3'd4, 4'b0100}: c = 8'd6;   // F ..-.
            {3'd3, 4'b0011}: c = 8'd7;   // G --.
            {3'd4, 4'b0000}: c = 8'd8;   // H ....
            {3'd2, 4'b0000}: c = 8'd9;   // I ..
            {3'd4, 4'b1110}: c = 8'd10;  // J .---
            {3'd3, 4'b0101}: c = 8'd11;  // K -.-
            {3'd4, 4'b0010}: c = 8'd12;  // L .-..
            {3'd2, 4'b0011}: c = 8'd13;  // M --
            {3'd2, 4'b0001}: c = 8'd14;  // N -.
            {3'd3, 4'b0111}: c = 8'd15;  // O ---
            {3'd4, 4'b0110}: c = 8'd16;  // P .--.
            {3'd4, 4'b1011}: c = 8'd17;  // Q --.-
            {3'd3, 4'b0010}: c = 8'd18;  // R .-.
            {3'd3, 4'b0000}: c = 8'd19;  // S ...
            {3'd1, 4'b0001}: c = 8'd20;  // T -
            {3'd3, 4'b0100}: c = 8'd21;  // U ..-
            {3'd4, 4'b1000}: c = 8'd22;  // V ...-
            {3'd3, 4'b0110}: c = 8'd23;  // W .--
            {3'd4, 4'b1001}: c = 8'd24;  // X -..-
            {3'd4, 4'b1101}: c = 8'd25;  // Y -.--
            {3'd4, 4'b0011}: c = 8'd26;  // Z --..
            default:         c = CODE_ERR;
         endcase
      end
      return c;
   endfunction

   assign code = lookup(len, bits, ovf);

   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb     <= 1'b0;
         deb_q   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
         deb_q <= deb;
         if (sync2 == deb) deb_cnt <= '0;
         else if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
            deb     <= sync2;
            deb_cnt <= '0;
         end else deb_cnt <= deb_cnt + DW'(1);
      end
   end

   // Unit count restarts on every debounced edge and saturates at 8.
   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         unit_cnt <= '0;
         units    <= 4'd0;
      end else if (rise || fall) begin
         unit_cnt <= '0;
         units    <= 4'd0;
      end else if (unit_cnt == UW'(UNIT_CYC - 1)) begin
         unit_cnt <= '0;
         if (units != 4'd8) units <= units + 4'd1;
      end else unit_cnt <= unit_cnt + UW'(1);
   end

   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= IDLE;
         len          <= 3'd0;
         bits         <= 4'd0;
         ovf          <= 1'b0;
         word_pending <= 1'b0;
         emit_space   <= 1'b0;
         letter       <= 8'd0;
         err          <= 1'b0;
         stb_go       <= 1'b0;
      end else begin
         stb_go <= 1'b0;
         case (state)
            IDLE: if (rise) state <= MARK;
            MARK: if (fall) begin
               if (len == 3'd4) ovf <= 1'b1;
               else begin
                  bits[len[1:0]] <= (units >= 4'd2);
                  len            <= len + 3'd1;
               end
               state <= GAP;
            end
            GAP: begin
               if (rise) state <= MARK;
               else if (units == 4'd3 && (len != 3'd0 || ovf)) begin
                  emit_space <= 1'b0;
                  state      <= EMIT;
               end else if (units == 4'd7 && word_pending) begin
                  emit_space <= 1'b1;
                  state      <= EMIT;
               end else if (units == 4'd8) state <= IDLE;
            end
            EMIT: begin
               if (emit_space) begin
                  letter       <= CODE_SPACE;
                  err          <= 1'b0;
                  word_pending <= 1'b0;
               end else begin
                  letter       <= code;
                  err          <= (code == CODE_ERR);
                  word_pending <= 1'b1;
               end
               len    <= 3'd0;
               bits   <= 4'd0;
               ovf    <= 1'b0;
               stb_go <= 1'b1;
               state  <= GAP;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobe starts the cycle after letter updates so the bus is settled first.
   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         stb_cnt    <= '0;
         letter_stb <= 1'b0;
      end else if (stb_go) begin
         stb_cnt    <= SW'(STB_CYC - 1);
         letter_stb <= 1'b1;
      end else if (stb_cnt != '0) stb_cnt <= stb_cnt - SW'(1);
      else letter_stb <= 1'b0;
   end
endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: table vectors, hand-written corner sequences and
// randomized keying checked against a string-level Morse model.
module tb_morse_key_decoder;
   localparam int DEB = 4, UNIT = 100, STB = 8;

   logic       clk = 1'b0, rst_n = 1'b1, key = 1'b0;
   logic [7:0] letter;
   logic       letter_stb, key_led, err;

   always #5 clk = ~clk;

   morse_key_decoder #(.DEBOUNCE_CYC(DEB), .UNIT_CYC(UNIT), .STB_CYC(STB)) dut (
      .CLOCK(clk), .RST_N(rst_n), .key_in(key), .letter(letter),
      .letter_stb(letter_stb), .key_led(key_led), .err(err));

   typedef struct { logic [7:0] code; logic err; } emit_t;
   typedef struct { string pat; int code; int err; } vec_t;

   int    n_pass = 0, n_total = 0, led_edges = 0, width = 0;
   logic  prev_stb = 1'b0, prev_led = 1'b0;
   emit_t exp_q[$], got_q[$];
   vec_t  vecs[10];
   string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

   task automatic chk(string name, int got, int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   always @(negedge clk) begin
      if (key_led !== prev_led) led_edges++;
      prev_led = key_led;
      if (letter_stb && !prev_stb) begin
         got_q.push_back('{letter, err});
         width = 0;
      end
      if (letter_stb) width++;
      if (!letter_stb && prev_stb) chk("stb_width", width, STB);
      prev_stb = letter_stb;
   end

   function automatic int ref_code(string p);
      if (p.len() > 4) return 29;
      for (int i = 0; i < 26; i++) if (p == morse[i]) return i + 1;
      return 29;
   endfunction

   task automatic expect_emit(int c);
      exp_q.push_back('{8'(c), (c == 29)});
   endtask

   task automatic hold(logic v, int n);
      key = v;
      repeat (n) @(posedge clk);
   endtask

   task automatic send(string p, int dot, int dash, int igap);
      for (int i = 0; i < p.len(); i++) begin
         hold(1'b1, (p[i] == "-") ? dash : dot);
         if (i < p.len() - 1) hold(1'b0, igap);
      end
   endtask

   task automatic compare(string name);
      chk({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_code%0d", name, i), got_q[i].code, exp_q[i].code);
         chk($sformatf("%s_err%0d", name, i), got_q[i].err, exp_q[i].err);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      vecs[0] = '{".", 5, 0};     vecs[1] = '{"-", 20, 0};
      vecs[2] = '{".-", 1, 0};    vecs[3] = '{"-.", 14, 0};
      vecs[4] = '{"...", 19, 0};  vecs[5] = '{"---", 15, 0};
      vecs[6] = '{"--.-", 17, 0}; vecs[7] = '{"-.--", 25, 0};
      vecs[8] = '{"-..-", 24, 0}; vecs[9] = '{"..--", 29, 1};

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_letter", letter, 0);
      chk("rst_stb", letter_stb, 0);
      chk("rst_led", key_led, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      hold(1'b0, 1000);
      compare("idle_no_strobe");
      chk("idle_letter", letter, 0);

      // single dot: E then space
      send(".", 100, 300, 100);
      hold(1'b0, 800);
      expect_emit(5); expect_emit(27);
      compare("dot_e");

      for (int v = 0; v < 10; v++) begin
         send(vecs[v].pat, 100, 300, 100);
         hold(1'b0, 1000);
         exp_q.push_back('{8'(vecs[v].code), vecs[v].err != 0});
         exp_q.push_back('{8'd27, 1'b0});
         compare($sformatf("vec%0d", v));
      end

      // A then N with a letter gap, then word gap
      send(".-", 100, 300, 100);
      hold(1'b0, 400);
      send("-.", 100, 300, 100);
      hold(1'b0, 800);
      expect_emit(1); expect_emit(14); expect_emit(27);
      compare("a_n");

      // bounce inside a press
      led_edges = 0;
      hold(1'b1, 60);
      for (int i = 0; i < 10; i++) begin
         hold(1'b0, 2);
         hold(1'b1, 2);
      end
      hold(1'b1, 60);
      chk("bounce_led_edges", led_edges, 1);
      hold(1'b0, 1000);
      expect_emit(5); expect_emit(27);
      compare("bounce");

      // overflow, then a valid letter clears err
      send(".....", 100, 300, 100);
      hold(1'b0, 400);
      chk("ovf_err_level", err, 1);
      chk("ovf_letter_level", letter, 29);
      send(".-", 100, 300, 100);
      hold(1'b0, 1000);
      chk("after_ovf_err_level", err, 0);
      expect_emit(29); expect_emit(1); expect_emit(27);
      compare("overflow");

      // long press saturates but still a single dash
      send("-", 100, 1200, 100);
      hold(1'b0, 1000);
      expect_emit(20); expect_emit(27);
      compare("long_dash");

      // reset mid-pattern
      send("..", 100, 300, 100);
      hold(1'b0, 50);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_letter", letter, 0);
      chk("midrst_err", err, 0);
      chk("midrst_stb", letter_stb, 0);
      rst_n = 1'b1;
      hold(1'b0, 1000);
      compare("midrst");
      chk("midrst_letter_after", letter, 0);

      // randomized keying against the string-level model
      for (int k = 0; k < 12; k++) begin
         string p;
         p = "";
         if ($urandom_range(0, 4) == 0) begin
            int n;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++)
               if ($urandom_range(0, 1) == 1) p = {p, "-"};
               else p = {p, "."};
         end else p = morse[$urandom_range(0, 25)];
         for (int i = 0; i < p.len(); i++) begin
            hold(1'b1, (p[i] == "-") ? $urandom_range(230, 900) : $urandom_range(30, 170));
            if (i < p.len() - 1) hold(1'b0, $urandom_range(30, 260));
         end
         expect_emit(ref_code(p));
         if (k == 11 || $urandom_range(0, 3) == 0) begin
            hold(1'b0, $urandom_range(760, 1000));
            expect_emit(27);
         end else hold(1'b0, $urandom_range(340, 640));
      end
      hold(1'b0, 200);
      compare("random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Upstream stage of the matrix display path. Samples a raw Morse key, debounces it, and times each press and gap in dot units.
- Assembles dot/dash patterns into letter codes.
- Presents each code on an 8-bit letter bus with a clean strobe, which the display interpreter uses as its load clock.
- Replaces the external microcontroller that currently generates letter/ardCLK.

Parameters:
DEBOUNCE_CYC, 500000, cycles key_in must be stable before a level change is accepted (10 ms at 50 MHz).
UNIT_CYC, 5000000, cycles per Morse dot unit (100 ms at 50 MHz).
STB_CYC, 64, width of the letter_stb high pulse in CLOCK cycles. Constraint: STB_CYC < UNIT_CYC.

Ports:
CLOCK  input  1  system clock, 50 MHz.
RST_N  input  1  asynchronous active-low reset.
key_in  input  1  raw key, active high, asynchronous to CLOCK.
letter  output  8  code of the last decoded character.
letter_stb  output  1  high for STB_CYC cycles per new code; drives the interpreter's ardCLK.
key_led  output  1  debounced key level.
err  output  1  sticky flag: last pattern was invalid. Cleared by the next valid emission.

Behaviour:
- Reset state: letter=0, letter_stb=0, key_led=0, err=0, FSM=IDLE, pattern cleared, word_pending=0.
- Input path:
  - key_in passes through a 2-FF synchronizer.
  - The debounce counter reloads on any change; the debounced level updates after DEBOUNCE_CYC stable cycles.
  - key_led = debounced level.
  - All timing below uses the debounced level.
- Unit timer: counts CLOCK cycles and emits a tick every UNIT_CYC cycles. It restarts on every debounced edge. The unit count saturates at 8.
- Pattern store: len[2:0] plus bits[3:0], filled oldest element first. Dot=0, dash=1.
- FSM states: IDLE, MARK, GAP, EMIT.
  - IDLE: a rising debounced edge goes to MARK.
  - MARK: on the falling edge, units<2 records a dot and units>=2 records a dash.
    - The element is appended; if len is already 4, set ovf instead.
    - Then go to GAP.
  - GAP, rising edge:
    - units<3: intra-letter gap; go to MARK.
    - Otherwise the letter has already been emitted.
  - GAP timeouts:
    - At units==3 with len>0 or ovf: go to EMIT (letter code).
    - At units==7 with word_pending=1: go to EMIT (space code 27) and clear word_pending.
    - At units==8: go to IDLE.
  - EMIT: lasts one cycle. letter updates. The strobe counter loads STB_CYC on the following cycle, so letter is stable ≥1 cycle before letter_stb rises. Pattern and ovf clear; return to GAP, keeping the unit count.
- Code table:
  - 1..26 = A..Z, using standard international Morse.
  - 27 = space.
  - 29 = error glyph, emitted when a pattern has no A..Z match or ovf=1.
  - Emitting 29 sets err. Emitting 1..27 clears err.
  - Codes 0, 28 and ≥30 are never emitted.
- word_pending is set on every emission of 1..26 or 29 and cleared when the space is emitted. Consecutive spaces therefore never occur.
- letter holds its value until the next emission. letter_stb is high for exactly STB_CYC cycles, then low. A new emission cannot arrive while letter_stb is high, because the 3-unit minimum and STB_CYC < UNIT_CYC prevent it.
- A press lasting ≥8 units still counts as a single dash (saturation).
- Reset asserted mid-pattern discards the pattern and forces every output to its reset value immediately. No strobe occurs after release of RST_N.

Test Plan (DEBOUNCE_CYC=4, UNIT_CYC=100, STB_CYC=8):
- Single dot: press 100 cycles, release and hold 800 cycles → one emission letter=5 ('E'), letter_stb high 8 cycles, then letter=27 with a second strobe. err=0.
- 'A' then 'N': dot, gap 100, dash 300; gap 400; dash 300, gap 100, dot 100; idle 800 → strobes with letter=1, then 14, then 27.
- Bounce: key_in toggles every 2 cycles for 40 cycles inside one press → key_led changes once and exactly one element is recorded.
- Overflow: five dots at 100-cycle spacing, then gap 400 → letter=29, err=1. The next '.-' gives letter=1 and err=0.
- Invalid pattern '..--' → letter=29. Long gap without any prior letter (idle 1000 after reset) → no strobe.
- Reset mid-pattern: assert RST_N low after two dots, release, idle 1000 → letter=0, letter_stb never rises.
